// File: rtl/brush_stamper_pkg.sv
// Shared project package: canvas geometry, color codes and the stamper FSM state type.
// Imported by the stamper top, its raster counter and the bench.
package brush_stamper_pkg;

    // Canvas geometry
    localparam int VGA_MAX_COORDINATE = 128;

    // Color codes
    localparam logic [2:0] COLOR_ERASE  = 3'd0;
    localparam logic [2:0] COLOR_RED    = 3'd1;
    localparam logic [2:0] COLOR_GREEN  = 3'd2;
    localparam logic [2:0] COLOR_BLUE   = 3'd3;
    localparam logic [2:0] COLOR_YELLOW = 3'd4;
    localparam logic [2:0] COLOR_CYAN   = 3'd5;
    localparam logic [2:0] COLOR_PINK   = 3'd6;
    localparam logic [2:0] COLOR_BLACK  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        STAMP,
        CLEAR
    } stamper_state_t;

    function automatic logic in_canvas(input logic [8:0] x, input logic [8:0] y,
                                       input logic [8:0] side);
        return (x < side) && (y < side);
    endfunction

endpackage

// File: rtl/brush_stamper_footprint_counter.sv
// 2-D raster offset counter (x inner, y outer) from (0,0) to (limit_x, limit_y).
// next_x/next_y give the offset that a step will load; last flags the final offset.
module footprint_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] limit_x,
    input  logic [7:0] limit_y,
    output logic [7:0] next_x,
    output logic [7:0] next_y,
    output logic       last
);

    logic [7:0] off_x;
    logic [7:0] off_y;
    logic [7:0] lim_x;
    logic [7:0] lim_y;
    logic       row_end;

    assign row_end = (off_x == lim_x);
    assign last    = row_end && (off_y == lim_y);
    assign next_x  = row_end ? 8'd0 : off_x + 8'd1;
    assign next_y  = row_end ? off_y + 8'd1 : off_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_x <= 8'd0;
            off_y <= 8'd0;
            lim_x <= 8'd0;
            lim_y <= 8'd0;
        end else if (start) begin
            off_x <= 8'd0;
            off_y <= 8'd0;
            lim_x <= limit_x;
            lim_y <= limit_y;
        end else if (step) begin
            off_x <= next_x;
            off_y <= next_y;
        end
    end

endmodule

// File: rtl/brush_stamper.sv
// Stamps a square brush or clears the canvas, one registered pixel write per cycle; pixel i in cycle i+1.
// cmd_ready is high only while idle; commands presented while busy are held off until then.
module brush_stamper
    import brush_stamper_pkg::*;
#(
    parameter int MAX_COORDINATE = VGA_MAX_COORDINATE,
    parameter int MAX_SIZE_BITS  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_clear,
    input  logic [7:0]               cmd_x,
    input  logic [7:0]               cmd_y,
    input  logic [2:0]               cmd_color,
    input  logic [MAX_SIZE_BITS-1:0] cmd_size,
    output logic                     brush,
    output logic [7:0]               wx,
    output logic [7:0]               wy,
    output logic [2:0]               newColor
);

    localparam logic [8:0] CANVAS_SIDE = 9'(MAX_COORDINATE);
    localparam logic [7:0] CLEAR_LIM   = 8'(MAX_COORDINATE - 1);

    stamper_state_t state;
    stamper_state_t state_nxt;

    logic [7:0] base_x;
    logic [7:0] base_y;
    logic       brush_nxt;
    logic [7:0] wx_nxt;
    logic [7:0] wy_nxt;
    logic [2:0] color_nxt;
    logic [8:0] px;
    logic [8:0] py;

    logic       cnt_start;
    logic       cnt_step;
    logic [7:0] cnt_lim;
    logic [7:0] cnt_nxt_x;
    logic [7:0] cnt_nxt_y;
    logic       cnt_last;

    assign cmd_ready = (state == IDLE);
    assign cnt_lim   = cmd_clear ? CLEAR_LIM : 8'(cmd_size);

    footprint_counter u_footprint (
        .clk     (clk),
        .reset   (reset),
        .start   (cnt_start),
        .step    (cnt_step),
        .limit_x (cnt_lim),
        .limit_y (cnt_lim),
        .next_x  (cnt_nxt_x),
        .next_y  (cnt_nxt_y),
        .last    (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        brush_nxt = 1'b0;
        wx_nxt    = wx;
        wy_nxt    = wy;
        color_nxt = newColor;
        cnt_start = 1'b0;
        cnt_step  = 1'b0;
        px        = 9'd0;
        py        = 9'd0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_start = 1'b1;
                    if (cmd_clear) begin
                        state_nxt = CLEAR;
                        brush_nxt = 1'b1;
                        wx_nxt    = 8'd0;
                        wy_nxt    = 8'd0;
                        color_nxt = COLOR_ERASE;
                    end else begin
                        state_nxt = STAMP;
                        px        = {1'b0, cmd_x};
                        py        = {1'b0, cmd_y};
                        brush_nxt = in_canvas(px, py, CANVAS_SIDE);
                        wx_nxt    = px[7:0];
                        wy_nxt    = py[7:0];
                        color_nxt = cmd_color;
                    end
                end
            end
            STAMP: begin
                if (cnt_last) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_step  = 1'b1;
                    // 9-bit sum so pixels past the canvas edge are masked, never wrapped
                    px        = {1'b0, base_x} + {1'b0, cnt_nxt_x};
                    py        = {1'b0, base_y} + {1'b0, cnt_nxt_y};
                    brush_nxt = in_canvas(px, py, CANVAS_SIDE);
                    wx_nxt    = px[7:0];
                    wy_nxt    = py[7:0];
                end
            end
            CLEAR: begin
                if (cnt_last) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_step  = 1'b1;
                    brush_nxt = 1'b1;
                    wx_nxt    = cnt_nxt_x;
                    wy_nxt    = cnt_nxt_y;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            brush    <= 1'b0;
            wx       <= 8'd0;
            wy       <= 8'd0;
            newColor <= COLOR_ERASE;
            base_x   <= 8'd0;
            base_y   <= 8'd0;
        end else begin
            state    <= state_nxt;
            brush    <= brush_nxt;
            wx       <= wx_nxt;
            wy       <= wy_nxt;
            newColor <= color_nxt;
            if (cmd_ready && cmd_valid) begin
                base_x <= cmd_x;
                base_y <= cmd_y;
            end
        end
    end

endmodule

// File: tb/tb_brush_stamper.sv
// Bench for brush_stamper: directed corner cases plus random stamps, checked cycle by cycle
// against a queue of expected pixel writes built from the command rules.
module tb_brush_stamper;
    import brush_stamper_pkg::*;

    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_clear = 1'b0;
    logic [7:0] cmd_x = 8'd0;
    logic [7:0] cmd_y = 8'd0;
    logic [2:0] cmd_color = 3'd0;
    logic [2:0] cmd_size = 3'd0;
    logic       cmd_ready;
    logic       brush;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] newColor;

    brush_stamper #(.MAX_COORDINATE(MAXC), .MAX_SIZE_BITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_color (cmd_color),
        .cmd_size  (cmd_size),
        .brush     (brush),
        .wx        (wx),
        .wy        (wy),
        .newColor  (newColor)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: every accepted command expands into its list of per-cycle writes
    typedef struct {
        bit b;
        int x;
        int y;
        int c;
    } pix_t;

    pix_t q[$];
    pix_t cur;
    bit   cur_active = 1'b0;
    bit   hold_known = 1'b1;
    int   hold_x = 0;
    int   hold_y = 0;
    int   hold_c = int'(COLOR_ERASE);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur_active = 1'b0;
            cur        = '{1'b0, 0, 0, int'(COLOR_ERASE)};
            hold_known = 1'b1;
            hold_x     = 0;
            hold_y     = 0;
            hold_c     = int'(COLOR_ERASE);
        end else begin
            if (!cur_active && cmd_valid) begin
                if (cmd_clear) begin
                    for (int yy = 0; yy < MAXC; yy++)
                        for (int xx = 0; xx < MAXC; xx++)
                            q.push_back('{1'b1, xx, yy, int'(COLOR_ERASE)});
                end else begin
                    for (int dy = 0; dy <= int'(cmd_size); dy++)
                        for (int dx = 0; dx <= int'(cmd_size); dx++) begin
                            int px;
                            int py;
                            px = int'(cmd_x) + dx;
                            py = int'(cmd_y) + dy;
                            q.push_back('{(px < MAXC) && (py < MAXC), px, py, int'(cmd_color)});
                        end
                end
            end
            if (q.size() > 0) begin
                cur        = q.pop_front();
                cur_active = 1'b1;
                if (cur.b) begin
                    hold_known = 1'b1;
                    hold_x     = cur.x;
                    hold_y     = cur.y;
                    hold_c     = cur.c;
                end else begin
                    hold_known = 1'b0;
                end
            end else begin
                cur_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_brush", int'(brush), 0);
            check("rst_wx", int'(wx), 0);
            check("rst_wy", int'(wy), 0);
            check("rst_color", int'(newColor), int'(COLOR_ERASE));
            check("rst_ready", int'(cmd_ready), 1);
        end else begin
            check("ready", int'(cmd_ready), int'(!cur_active));
            check("brush", int'(brush), int'(cur_active && cur.b));
            if (cur_active && cur.b) begin
                check("wx", int'(wx), cur.x);
                check("wy", int'(wy), cur.y);
                check("color", int'(newColor), cur.c);
            end else if (!cur_active && hold_known) begin
                check("hold_wx", int'(wx), hold_x);
                check("hold_wy", int'(wy), hold_y);
                check("hold_color", int'(newColor), hold_c);
            end
        end
    end

    // Present a command and keep it up until the edge that accepts it; returns just after that edge
    task automatic send(input bit clr, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] c, input logic [2:0] s);
        int t;
        cmd_valid = 1'b1;
        cmd_clear = clr;
        cmd_x     = x;
        cmd_y     = y;
        cmd_color = c;
        cmd_size  = s;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 20000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("ready_after_reset", int'(cmd_ready), 1);

        send(1'b0, 8'd10, 8'd20, COLOR_RED, 3'd1);
        idle(8);
        send(1'b0, 8'd0, 8'd0, COLOR_BLUE, 3'd0);
        idle(4);
        send(1'b0, 8'd126, 8'd126, COLOR_GREEN, 3'd3);
        idle(20);
        send(1'b1, 8'd77, 8'd55, COLOR_PINK, 3'd5);
        idle(16400);
        send(1'b0, 8'd3, 8'd4, COLOR_YELLOW, 3'd2);
        send(1'b0, 8'd60, 8'd61, COLOR_CYAN, 3'd1);
        idle(12);

        // Asynchronous reset in the middle of pixel cycle 3 of a 3x3 stamp
        send(1'b0, 8'd40, 8'd50, COLOR_GREEN, 3'd2);
        idle(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_async_brush", int'(brush), 0);
        check("rst_async_ready", int'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("ready_after_release", int'(cmd_ready), 1);
        idle(12);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rx;
            logic [7:0] ry;
            if ($urandom_range(0, 1) == 0) begin
                rx = 8'($urandom_range(118, 135));
                ry = 8'($urandom_range(118, 135));
            end else begin
                rx = 8'($urandom_range(0, 255));
                ry = 8'($urandom_range(0, 255));
            end
            send(1'b0, rx, ry, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brush_stamper.md
BRUSH_STAMPER -- requirements
Module: brush_stamper

Interface
REQ-001 SHALL have parameter MAX_COORDINATE, default 128: canvas side in pixels; value taken from the shared VGA parameters header.
REQ-002 SHALL have parameter MAX_SIZE_BITS, default 3: width of cmd_size.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_clear  input  1  command is a full-canvas clear; qualified by cmd_valid.
REQ-008 SHALL have ports cmd_x, cmd_y  input  8 each  stamp top-left corner.
REQ-009 SHALL have port cmd_color  input  3  stamp color code.
REQ-010 SHALL have port cmd_size  input  MAX_SIZE_BITS  brush side minus one (side 1..8).
REQ-011 SHALL have port brush  output  1  pixel write strobe to the pixel store.
REQ-012 SHALL have ports wx, wy  output  8 each  write coordinates.
REQ-013 SHALL have port newColor  output  3  write color.

Function
REQ-014 SHALL implement FSM states IDLE, STAMP and CLEAR.
REQ-015 SHALL drive cmd_ready high only in IDLE.
REQ-016 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1, and ignore cmd_valid at all other times.
REQ-017 SHALL, on acceptance, register cmd_x, cmd_y, cmd_color and cmd_size, then enter STAMP, or enter CLEAR when cmd_clear=1; cmd_clear takes priority over the stamp fields.
REQ-018 SHALL in STAMP emit side*side pixels, one per cycle, in raster order (x inner loop, y outer loop), starting at (cmd_x, cmd_y).
REQ-019 SHALL present pixel i (i from 0) in cycle i+1 after the accepting edge; all outputs are registered.
REQ-020 SHALL compute pixel coordinates at 9-bit width; a pixel with x or y >= MAX_COORDINATE drives brush=0 for its cycle but still consumes that cycle (fixed latency side*side, no wrap-around).
REQ-021 SHALL drive newColor = registered color and brush=1 for in-range STAMP pixels.
REQ-022 SHALL in CLEAR sweep (0,0)..(MAX_COORDINATE-1, MAX_COORDINATE-1) in raster order with brush=1 and newColor = the erase code, taking MAX_COORDINATE^2 cycles.
REQ-023 SHALL return to IDLE after the last pixel cycle, so cmd_ready is high in the following cycle.
REQ-024 SHALL drive brush=0 in IDLE and SHALL hold wx, wy and newColor at their last values in IDLE.
REQ-025 SHALL treat cmd_size=0 as a single-pixel write.

Reset
REQ-026 SHALL, while reset=0, immediately force state=IDLE, brush=0, wx=0, wy=0, newColor=erase code and all counters to 0.
REQ-027 SHALL abandon an in-progress stamp or clear on reset, with no further writes after reset is released.
REQ-028 SHALL drive cmd_ready high in the first cycle after reset is released.

Structure
REQ-029 SHALL take MAX_COORDINATE from the shared VGA parameters header and color codes (erase, red, ...) from the shared colors header.
REQ-030 SHALL define the FSM state typedef in the shared project package.
REQ-031 SHALL contain one sub-module, footprint_counter: a 2-D x/y raster counter with start, limit, step and last outputs, reused by STAMP and CLEAR.
REQ-032 SHALL fit in 120-400 lines of RTL, excluding the shared package.

Verification
REQ-033 SHALL cover: stamp x=10, y=20, size=1, color=red -> writes (10,20), (11,20), (10,21), (11,21) in cycles 1-4 after acceptance; cmd_ready=1 in cycle 5.
REQ-034 SHALL cover: stamp x=126, y=126, size=3 -> 16 cycles; brush=1 only for (126,126), (127,126), (126,127), (127,127); no coordinate wrap.
REQ-035 SHALL cover: clear -> 16384 consecutive writes with the erase code, first (0,0), last (127,127); cmd_ready=1 in the next cycle.
REQ-036 SHALL cover: cmd_valid held high with a second command during a stamp -> second command accepted only in the first cycle with cmd_ready=1; no first-stamp pixel dropped.
REQ-037 SHALL cover: reset=0 asynchronously in pixel cycle 3 of a size=2 stamp -> brush=0 before the next edge; after release cmd_ready=1 and no residual writes.
REQ-038 SHALL cover: size=0, x=0, y=0 -> exactly one write at (0,0) in cycle 1; cmd_ready=1 in cycle 2.
